// File: rtl/bandgap_startup_ctrl.sv
// bandgap_startup_ctrl: sequences bandgap enable, settle/timeout supervision and fault latching.
module bandgap_startup_ctrl #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en_req,
    input  logic       bg_ok,
    input  logic       clr_fault,
    output logic       bg_en,
    output logic       bg_ready,
    output logic       bg_fault,
    output logic [1:0] state
);
    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    localparam logic [CNT_W-1:0] SETTLE_M1  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             ok_m_q, ok_s_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bg_en_q, bg_ready_q, bg_fault_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:   state_d = en_req ? S_WAIT : S_OFF;
            S_WAIT:  state_d = !en_req                          ? S_OFF   :
                               (cnt_q >= SETTLE_M1 && ok_s_q)   ? S_READY :
                               (cnt_q == TIMEOUT_M1)            ? S_FAULT : S_WAIT;
            S_READY: state_d = !en_req ? S_OFF : (!ok_s_q ? S_FAULT : S_READY);
            default: state_d = clr_fault ? S_OFF : S_FAULT;
        endcase
    end

    // Counter restarts on every WAIT entry so an earlier attempt never carries over.
    assign cnt_d = (state_d == S_WAIT && state_q == S_WAIT)
                 ? ((cnt_q == TIMEOUT_M1) ? cnt_q : cnt_q + 1'b1) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ok_m_q     <= 1'b0;
            ok_s_q     <= 1'b0;
            state_q    <= S_OFF;
            cnt_q      <= '0;
            bg_en_q    <= 1'b0;
            bg_ready_q <= 1'b0;
            bg_fault_q <= 1'b0;
        end else begin
            ok_m_q     <= bg_ok;
            ok_s_q     <= ok_m_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bg_en_q    <= (state_d == S_WAIT) || (state_d == S_READY);
            bg_ready_q <= (state_d == S_READY);
            bg_fault_q <= (state_d == S_FAULT);
        end
    end

    assign bg_en    = bg_en_q;
    assign bg_ready = bg_ready_q;
    assign bg_fault = bg_fault_q;
    assign state    = state_q;
endmodule

// File: tb/tb_bandgap_startup_ctrl.sv
// tb_bandgap_startup_ctrl: directed plus random stimulus, scoreboarded against a cycle model.
module tb_bandgap_startup_ctrl;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en_req = 1'b0;
    logic       bg_ok = 1'b0;
    logic       clr_fault = 1'b0;
    logic       bg_en, bg_ready, bg_fault;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic [4:0] expq[$];

    int m_st = 0;
    int m_w = 0;
    bit okq[$] = '{1'b0, 1'b0};

    bandgap_startup_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .en_req(en_req), .bg_ok(bg_ok), .clr_fault(clr_fault),
        .bg_en(bg_en), .bg_ready(bg_ready), .bg_fault(bg_fault), .state(state)
    );

    always #5 clk = ~clk;

    // Reference: 0=off 1=wait 2=ready 3=fault; m_w counts cycles spent in the current wait.
    task automatic model_edge(input bit en, input bit ok, input bit clr, input bit rst_n);
        bit oks;
        if (!rst_n) begin
            m_st = 0;
            m_w  = 0;
            okq  = '{1'b0, 1'b0};
        end else begin
            oks = okq.pop_front();
            okq.push_back(ok);
            if (m_st == 0) begin
                if (en) begin m_st = 1; m_w = 0; end
            end else if (m_st == 1) begin
                if (!en) m_st = 0;
                else if (m_w >= SETTLE - 1 && oks) m_st = 2;
                else if (m_w >= TIMEOUT - 1) m_st = 3;
                else m_w++;
            end else if (m_st == 2) begin
                if (!en) m_st = 0;
                else if (!oks) m_st = 3;
            end else if (clr) begin
                m_st = 0;
            end
        end
        expq.push_back({2'(m_st), m_st == 1 || m_st == 2, m_st == 2, m_st == 3});
    endtask

    task automatic cyc(input bit en, input bit ok, input bit clr, input bit rst_n);
        @(negedge clk);
        en_req = en; bg_ok = ok; clr_fault = clr; resetn = rst_n;
        model_edge(en, ok, clr, rst_n);
    endtask

    task automatic run(input int n, input bit en, input bit ok, input bit clr);
        for (int i = 0; i < n; i++) cyc(en, ok, clr, 1'b1);
    endtask

    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if ({state, bg_en, bg_ready, bg_fault} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got state=%0d en=%b rdy=%b flt=%b exp state=%0d en=%b rdy=%b flt=%b",
                             $time, state, bg_en, bg_ready, bg_fault, e[4:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        bit en, ok, clr, rn;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1, 1'b0);
        run(12, 1'b1, 1'b1, 1'b0);
        run(5, 1'b1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b1);
        run(25, 1'b1, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0, 1'b0);
        run(13, 1'b1, 1'b0, 1'b0);
        run(8, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1, 1'b0);
        run(5, 1'b1, 1'b1, 1'b0);
        // Async reset mid-wait: bg_en must fall before any clock edge.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (bg_en !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got en=%b state=%0d exp en=0 state=0", bg_en, state);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run(12, 1'b1, 1'b1, 1'b0);
        en = 1'b1; ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) en = ~en;
            if ($urandom_range(0, 11) == 0) ok = ~ok;
            clr = ($urandom_range(0, 7) == 0);
            rn  = ($urandom_range(0, 499) != 0);
            cyc(en, ok, clr, rn);
        end
        @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bandgap_startup_ctrl.md
BANDGAP_STARTUP_CTRL -- requirements
Module: bandgap_startup_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and resetn as elsewhere in the codebase.
REQ-002 Parameter SETTLE_CYCLES, default 1000: minimum number of cycles bg_en is held high before readiness may be declared.
REQ-003 Parameter TIMEOUT_CYCLES, default 4000: number of cycles after enable by which bg_ok must be seen, otherwise the block faults.
REQ-004 Parameter CNT_W, default 16: settle counter width; the legal range is 1 <= SETTLE_CYCLES <= TIMEOUT_CYCLES < 2^CNT_W.
REQ-005 The block SHALL have the following ports:
- clk  input  1  system clock.
- resetn  input  1  async active-low reset.
- en_req  input  1  synchronous level request to power up the bandgap (system register bit).
- bg_ok  input  1  asynchronous window-comparator flag, high when VBGP is in range.
- clr_fault  input  1  synchronous level; clears the fault state.
- bg_en  output  1  registered enable driven to the bandgap EN pin.
- bg_ready  output  1  registered; reference is settled and valid.
- bg_fault  output  1  registered; startup timeout or loss of reference.
- state  output  2  registered current state: OFF=0, WAIT=1, READY=2, FAULT=3.

Function
REQ-006 bg_ok SHALL pass through a 2-flop synchronizer; ok_s (second flop) is the only internal use of bg_ok, giving 2 cycles of latency.
REQ-007 OFF: bg_en=0, bg_ready=0, bg_fault=0, counter held at 0; en_req=1 SHALL move the block to WAIT on the next edge.
REQ-008 WAIT: bg_en=1; the counter SHALL increment every cycle starting from 0 on WAIT entry, saturating at TIMEOUT_CYCLES-1.
REQ-009 WAIT -> READY SHALL occur on the first cycle with counter >= SETTLE_CYCLES-1 and ok_s=1.
REQ-010 WAIT -> FAULT SHALL occur on the cycle with counter == TIMEOUT_CYCLES-1 and ok_s=0.
REQ-011 If both REQ-009 and REQ-010 conditions are evaluated in the same cycle, READY SHALL win, because ok_s=1 excludes FAULT.
REQ-012 READY: bg_en=1, bg_ready=1; ok_s=0 SHALL move the block to FAULT on the next edge.
REQ-013 FAULT: bg_en=0, bg_ready=0, bg_fault=1; the block SHALL stay in FAULT regardless of en_req until clr_fault=1, then go to OFF.
REQ-014 After leaving FAULT, if en_req is still 1, OFF SHALL go to WAIT on the following edge (a retry takes 2 cycles after clr_fault).
REQ-015 In WAIT or READY, en_req=0 SHALL move the block to OFF next edge, with priority over every other transition, including ok_s loss.
REQ-016 All outputs SHALL be decoded from the registered next state so that they change on the same edge as state; no combinational output paths.
REQ-017 The counter SHALL be zeroed on every entry to WAIT; time spent in an earlier WAIT SHALL NOT carry over.
REQ-018 clr_fault SHALL be ignored outside FAULT.

Reset
REQ-019 While resetn=0, asynchronously: state=OFF, bg_en=0, bg_ready=0, bg_fault=0, counter=0, both synchronizer flops=0.
REQ-020 Reset assertion mid-WAIT or mid-READY SHALL drop bg_en immediately, without waiting for a clock edge.
REQ-021 After resetn rises, the block SHALL leave OFF only on a clk edge with en_req=1.

Verification (SETTLE_CYCLES=8, TIMEOUT_CYCLES=20)
REQ-022 Normal start: bg_ok=1 held and en_req raised at edge 0 -> bg_en=1 at edge 1; bg_ready=1 at edge 9; state=2.
REQ-023 Late ok: bg_ok rises at counter=12 -> bg_ready rises 3 edges later, with no fault.
REQ-024 Timeout and clear:
- bg_ok=0 throughout -> bg_fault=1 and bg_en=0 exactly 20 edges after WAIT entry.
- clr_fault=1 with en_req=1 -> state 3->0->1.
REQ-025 Loss of reference: in READY, drop bg_ok -> bg_fault=1 after 3 edges; a bg_ok pulse shorter than 1 cycle may be missed.
REQ-026 Priority and reset:
- en_req=0 in the same cycle ok_s falls in READY -> state=OFF, bg_fault=0.
- resetn pulsed low mid-WAIT -> bg_en=0 asynchronously, and the counter restarts at 0 on re-entry to WAIT.
